stms_input_conditioner: RTL and testbench
=========================================

Name: stms_input_conditioner

Overview:
- Front-end stage that feeds the traffic-light controller.
- Synchronises and debounces the four raw lane-occupancy sensors.
- Qualifies raw ambulance and police requests into clean alert1/alert2 levels with minimum hold and cooldown.
- Stretches a manual emergency input into a clean emrg level. All outputs connect directly to the controller's like-named inputs.

Parameters:
DEB_CYCLES, 4, consecutive synchronised cycles a new level must persist before it is accepted (1..15).
EMRG_HOLD, 8, minimum cycles alert1/alert2/emrg stay asserted once asserted (1..255).
COOLDOWN, 16, cycles after an alert ends during which new vehicle requests are ignored (0..255).

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
raw_sensor  in  4  unsynchronised lane sensors, bit0=N, bit1=E, bit2=S, bit3=W
raw_amb_req  in  1  unsynchronised ambulance-detector request
raw_pol_req  in  1  unsynchronised police-detector request
raw_manual_emrg  in  1  unsynchronised manual emergency push-button
sensor_north/east/south/west  out  1 each  debounced lane occupancy
alert1  out  1  qualified ambulance alert (level)
alert2  out  1  qualified police alert (level)
emrg  out  1  stretched manual emergency (level)
occupancy  out  3  popcount of the four debounced sensors (0..4)
sensor_chg  out  1  one-cycle pulse when any debounced sensor changes

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. Every flop clears on rst: all outputs 0, synchronisers 0, counters 0, FSM in IDLE.
- Sync: every raw input passes through a 2-flop synchroniser. "Synced" below means the second flop.
- Debounce, per sensor:
  - A counter increments while synced != debounced output and clears whenever they are equal.
  - When the counter reaches DEB_CYCLES, the output takes the synced value and the counter clears.
  - Latency for a clean edge: the output changes at the (2+DEB_CYCLES)th rising edge after the first edge that samples the new raw level.
  - A pulse shorter than DEB_CYCLES synced cycles never reaches the output.
- sensor_chg: high for exactly the cycle after any debounced sensor register updates. Simultaneous changes give a single pulse.
- occupancy: registered popcount, updates in the same cycle as sensor_chg.
- Alert FSM states: IDLE, QUAL, ACTIVE, COOL.
  - IDLE: if synced amb or pol is high, go to QUAL. Latch cls=AMB if amb is high, else POL. Counter=1.
  - QUAL:
    - If the request for cls drops, go to IDLE.
    - If cls=POL and amb rises, set cls=AMB and restart the counter at 1.
    - When the counter reaches DEB_CYCLES, go to ACTIVE. Assert alert1 (AMB) or alert2 (POL) on the next edge. Hold counter=0.
  - ACTIVE:
    - Hold counter saturates at EMRG_HOLD.
    - Upgrade: if cls=POL and synced amb is high, alert2 drops and alert1 rises on the same edge, cls=AMB, hold counter restarts.
    - Exit when the cls request is low AND the hold counter is >= EMRG_HOLD: go to COOL, alerts drop.
  - COOL: outputs 0 and all requests ignored for COOLDOWN cycles, then go to IDLE. COOLDOWN=0 goes directly to IDLE.
  - alert1 and alert2 are never high together.
- Manual emergency:
  - A rising edge of synced manual loads the emrg counter with EMRG_HOLD and sets emrg=1. emrg falls when the counter reaches 0.
  - A new rising edge while emrg=1 reloads the counter (retrigger extends).
  - While emrg=1, the alert FSM is forced to IDLE and alert1 = alert2 = 0. Emergency preempts vehicle alerts, including mid-ACTIVE and mid-COOL.
- Assertion of rst mid-operation aborts any qualification, hold or cooldown immediately. No state survives.
- All counters are sized from their parameter (clog2(max+1)) and never wrap.

Decomposition:
- Package stms_pkg holds:
  - the alert FSM state enum (IDLE, QUAL, ACTIVE, COOL);
  - the class enum (AMB, POL);
  - direction index constants DIR_N=0, DIR_E=1, DIR_S=2, DIR_W=3.
- One sub-module, stms_debounce: a single channel containing synchroniser, counter and output register, parameterised by DEB_CYCLES. It is instantiated four times for the sensors.
- The alert FSM and the emrg stretcher stay in the top module.

Test Plan:
- Reset with all raw inputs = 1 → after 6 clocks all four sensors = 1, occupancy = 4, exactly one sensor_chg pulse; during rst all outputs = 0.
- raw_sensor[0] low for 3 clocks, then high → sensor_north unchanged and no sensor_chg. Low for 10 clocks → sensor_north falls 6 edges after the drop, occupancy = 3.
- raw_pol_req high for 20 clocks → alert2 rises at edge 2+4+1. Hold raw_pol_req high, then raise raw_amb_req at alert2 cycle 3 → alert2 falls and alert1 rises on the same edge, and alert1 stays high for at least 8 cycles.
- Short request: raw_amb_req high for 2 clocks → no alert. Raw_amb_req pulse shorter than EMRG_HOLD after qualification → alert1 high exactly 8 cycles, then a new request during the next 16 cycles is ignored.
- raw_manual_emrg one-clock pulse while alert1 is active → emrg high 8 cycles, alert1 = 0 during those cycles. Second pulse 5 cycles later → emrg stays high for 8 cycles after the retrigger.
- Assert rst mid-ACTIVE and mid-COOL → all outputs 0 asynchronously. After release, the FSM is in IDLE and a request qualifies in the normal DEB_CYCLES.

Source files
------------

// File: rtl/stms_pkg.sv
// Shared types and constants for the STMS input conditioner.
// Holds the alert FSM state enum, alert class, lane indices and a popcount helper.
package stms_pkg;

    typedef enum logic [1:0] {
        IDLE,
        QUAL,
        ACTIVE,
        COOL
    } alert_state_t;

    typedef enum logic {
        AMB,
        POL
    } alert_cls_t;

    localparam int DIR_N = 0;
    localparam int DIR_E = 1;
    localparam int DIR_S = 2;
    localparam int DIR_W = 3;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/stms_debounce.sv
// One lane-sensor channel: 2-flop synchroniser, persistence counter and debounced level.
// Level follows a new synced value after DEB_CYCLES consecutive cycles; no backpressure, upd pulses on that edge.
module stms_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic upd
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          meta;
    logic          synced;
    logic [CW-1:0] cnt;

    // The counter reaches DEB_CYCLES on the same edge that moves the level.
    assign upd = (synced != level) && (cnt == CW'(DEB_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta   <= 1'b0;
            synced <= 1'b0;
            cnt    <= '0;
            level  <= 1'b0;
        end else begin
            meta   <= raw;
            synced <= meta;
            if (synced == level) begin
                cnt <= '0;
            end else if (upd) begin
                cnt   <= '0;
                level <= synced;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/stms_input_conditioner.sv
// Front end for the traffic-light controller: debounced lane sensors, qualified vehicle alerts, stretched manual emergency.
// Sensors settle 2+DEB_CYCLES edges after a clean raw edge, alerts 3+DEB_CYCLES; no backpressure, all outputs are levels/pulses.
module stms_input_conditioner
    import stms_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int EMRG_HOLD  = 8,
    parameter int COOLDOWN   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] raw_sensor,
    input  logic       raw_amb_req,
    input  logic       raw_pol_req,
    input  logic       raw_manual_emrg,
    output logic       sensor_north,
    output logic       sensor_east,
    output logic       sensor_south,
    output logic       sensor_west,
    output logic       alert1,
    output logic       alert2,
    output logic       emrg,
    output logic [2:0] occupancy,
    output logic       sensor_chg
);

    localparam int M1   = (DEB_CYCLES > EMRG_HOLD) ? DEB_CYCLES : EMRG_HOLD;
    localparam int MAXP = (M1 > COOLDOWN) ? M1 : COOLDOWN;
    localparam int CW   = $clog2(MAXP + 1);
    localparam int EW   = $clog2(EMRG_HOLD + 1);

    logic [3:0]    level;
    logic [3:0]    upd;
    logic [2:0]    req_meta;
    logic [2:0]    req_sync;
    logic          man_prev;
    logic          man_rise;
    logic [EW-1:0] ecnt;
    logic          amb;
    logic          pol;
    logic          req;

    alert_state_t  state, state_nxt;
    alert_cls_t    cls, cls_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    for (genvar i = 0; i < 4; i++) begin : g_deb
        stms_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk   (clk),
            .rst   (rst),
            .raw   (raw_sensor[i]),
            .level (level[i]),
            .upd   (upd[i])
        );
    end

    assign sensor_north = level[DIR_N];
    assign sensor_east  = level[DIR_E];
    assign sensor_south = level[DIR_S];
    assign sensor_west  = level[DIR_W];

    // level ^ upd is the level after this edge, so occupancy lines up with sensor_chg.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sensor_chg <= 1'b0;
            occupancy  <= '0;
        end else begin
            sensor_chg <= |upd;
            occupancy  <= popcount4(level ^ upd);
        end
    end

    assign amb      = req_sync[0];
    assign pol      = req_sync[1];
    assign man_rise = req_sync[2] & ~man_prev;
    assign emrg     = (ecnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_meta <= '0;
            req_sync <= '0;
            man_prev <= 1'b0;
            ecnt     <= '0;
        end else begin
            req_meta <= {raw_manual_emrg, raw_pol_req, raw_amb_req};
            req_sync <= req_meta;
            man_prev <= req_sync[2];
            if (man_rise) begin
                ecnt <= EW'(EMRG_HOLD);
            end else if (ecnt != '0) begin
                ecnt <= ecnt - EW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cls   <= AMB;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cls   <= cls_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cls_nxt   = cls;
        cnt_nxt   = cnt;
        req       = (cls == AMB) ? amb : pol;
        // A manual emergency (or one starting this edge) parks the FSM in IDLE.
        if (emrg || man_rise) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (amb || pol) begin
                        state_nxt = QUAL;
                        cls_nxt   = amb ? AMB : POL;
                        cnt_nxt   = CW'(1);
                    end
                end
                QUAL: begin
                    if (!req) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (cls == POL && amb) begin
                        cls_nxt = AMB;
                        cnt_nxt = CW'(1);
                    end else if (cnt == CW'(DEB_CYCLES)) begin
                        state_nxt = ACTIVE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                ACTIVE: begin
                    // The current cycle counts toward the hold, hence the +1.
                    if (cls == POL && amb) begin
                        cls_nxt = AMB;
                        cnt_nxt = '0;
                    end else if (!req && (int'(cnt) + 1 >= EMRG_HOLD)) begin
                        state_nxt = (COOLDOWN == 0) ? IDLE : COOL;
                        cnt_nxt   = '0;
                    end else if (int'(cnt) < EMRG_HOLD) begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                COOL: begin
                    if (int'(cnt) + 1 >= COOLDOWN) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign alert1 = (state == ACTIVE) && (cls == AMB);
    assign alert2 = (state == ACTIVE) && (cls == POL);

endmodule

// File: tb/tb_stms_input_conditioner.sv
// Self-checking bench: timestamp/history reference model of the conditioner plus directed timing checks.
module tb_stms_input_conditioner;

    localparam int DEB_CYCLES = 4;
    localparam int EMRG_HOLD  = 8;
    localparam int COOLDOWN   = 16;
    localparam int HN         = 8192;
    localparam int P_IDLE = 0, P_QUAL = 1, P_ACT = 2, P_COOL = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] raw_sensor;
    logic       raw_amb_req, raw_pol_req, raw_manual_emrg;
    logic       sensor_north, sensor_east, sensor_south, sensor_west;
    logic       alert1, alert2, emrg, sensor_chg;
    logic [2:0] occupancy;

    int ntests = 0;
    int nfail  = 0;

    stms_input_conditioner #(
        .DEB_CYCLES(DEB_CYCLES), .EMRG_HOLD(EMRG_HOLD), .COOLDOWN(COOLDOWN)
    ) dut (
        .clk(clk), .rst(rst), .raw_sensor(raw_sensor),
        .raw_amb_req(raw_amb_req), .raw_pol_req(raw_pol_req), .raw_manual_emrg(raw_manual_emrg),
        .sensor_north(sensor_north), .sensor_east(sensor_east),
        .sensor_south(sensor_south), .sensor_west(sensor_west),
        .alert1(alert1), .alert2(alert2), .emrg(emrg),
        .occupancy(occupancy), .sensor_chg(sensor_chg)
    );

    always #5 clk = ~clk;

    // Reference model: raw-sample history per edge since reset, timestamps instead of counters.
    logic [3:0] h_sens [HN];
    logic       h_amb [HN], h_pol [HN], h_man [HN];
    int         e, t0, last_rise, phase;
    bit         have_rise;
    logic [3:0] m_sens;
    logic       m_chg, m_emrg, m_amb;
    logic [2:0] m_occ;

    logic [10:0] dut_vec, exp_vec;
    assign dut_vec = {sensor_west, sensor_south, sensor_east, sensor_north, sensor_chg, occupancy,
                      alert1, alert2, emrg};
    assign exp_vec = {m_sens, m_chg, m_occ, (phase == P_ACT) && m_amb, (phase == P_ACT) && !m_amb, m_emrg};

    function automatic logic [3:0] sens_at(int k);
        return (k < 1) ? 4'h0 : h_sens[k];
    endfunction
    function automatic logic amb_at(int k);
        return (k < 1) ? 1'b0 : h_amb[k];
    endfunction
    function automatic logic pol_at(int k);
        return (k < 1) ? 1'b0 : h_pol[k];
    endfunction
    function automatic logic man_at(int k);
        return (k < 1) ? 1'b0 : h_man[k];
    endfunction

    task automatic model_reset();
        e = 0; t0 = 0; last_rise = 0; phase = P_IDLE; have_rise = 0;
        m_sens = 4'h0; m_chg = 1'b0; m_occ = 3'd0; m_emrg = 1'b0; m_amb = 1'b0;
    endtask

    task automatic model_step();
        logic [3:0] w;
        logic diff, amb, pol, rise, force_idle, req;
        e++;
        h_sens[e] = raw_sensor; h_amb[e] = raw_amb_req; h_pol[e] = raw_pol_req; h_man[e] = raw_manual_emrg;
        // A lane flips when its last DEB_CYCLES synced values all differ from the current level.
        m_chg = 1'b0;
        for (int j = 0; j < 4; j++) begin
            diff = 1'b1;
            for (int k = e - DEB_CYCLES - 1; k <= e - 2; k++) begin
                w = sens_at(k);
                if (w[j] == m_sens[j]) diff = 1'b0;
            end
            if (diff) begin
                m_sens[j] = ~m_sens[j];
                m_chg = 1'b1;
            end
        end
        m_occ = 3'($countones(m_sens));
        amb  = amb_at(e - 2);
        pol  = pol_at(e - 2);
        rise = man_at(e - 2) && !man_at(e - 3);
        force_idle = m_emrg || rise;
        if (rise) begin
            have_rise = 1'b1;
            last_rise = e;
        end
        m_emrg = have_rise && (e - last_rise < EMRG_HOLD);
        req = m_amb ? amb : pol;
        if (force_idle) begin
            phase = P_IDLE;
        end else begin
            case (phase)
                P_IDLE: if (amb || pol) begin phase = P_QUAL; m_amb = amb; t0 = e; end
                P_QUAL: begin
                    if (!req) phase = P_IDLE;
                    else if (!m_amb && amb) begin m_amb = 1'b1; t0 = e; end
                    else if (e - t0 == DEB_CYCLES) begin phase = P_ACT; t0 = e; end
                end
                P_ACT: begin
                    if (!m_amb && amb) begin m_amb = 1'b1; t0 = e; end
                    else if (!req && (e - t0 >= EMRG_HOLD)) begin
                        phase = (COOLDOWN == 0) ? P_IDLE : P_COOL;
                        t0 = e;
                    end
                end
                default: if (e - t0 >= COOLDOWN) phase = P_IDLE;
            endcase
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else if (e < HN - 1) model_step();
        end
    end

    task automatic test_reset();
        int pulses = 0;
        repeat (3) @(negedge clk);
        ntests++;
        if (dut_vec !== 11'b0) begin nfail++; $display("FAIL reset_hold: got %b want 0", dut_vec); end
        rst = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            @(posedge clk); @(negedge clk);
            ntests++;
            if (dut_vec !== exp_vec) begin nfail++; $display("FAIL reset cyc %0d: got %b want %b", c, dut_vec, exp_vec); end
            if (c <= 10 && sensor_chg) pulses++;
            if (c == 6) begin
                ntests++;
                if ({sensor_west, sensor_south, sensor_east, sensor_north, occupancy} !== 7'b1111_100) begin
                    nfail++; $display("FAIL reset_sensors: got %b%b%b%b occ %0d want 1111 occ 4",
                                      sensor_west, sensor_south, sensor_east, sensor_north, occupancy);
                end
            end
            if (c == 10) begin raw_amb_req = 0; raw_pol_req = 0; raw_manual_emrg = 0; end
        end
        ntests++;
        if (pulses != 1) begin nfail++; $display("FAIL reset_chg_pulses: got %0d want 1", pulses); end
    endtask

    task automatic test_debounce();
        raw_sensor[0] = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); @(negedge clk);
            ntests++;
            if (dut_vec !== exp_vec) begin nfail++; $display("FAIL glitch cyc %0d: got %b want %b", c, dut_vec, exp_vec); end
            ntests++;
            if (sensor_north !== 1'b1 || sensor_chg !== 1'b0) begin
                nfail++; $display("FAIL glitch_north cyc %0d: north %b chg %b want 1 0", c, sensor_north, sensor_chg);
            end
            if (c == 3) raw_sensor[0] = 1'b1;
        end
        raw_sensor[0] = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); @(negedge clk);
            ntests++;
            if (dut_vec !== exp_vec) begin nfail++; $display("FAIL drop cyc %0d: got %b want %b", c, dut_vec, exp_vec); end
            if (c == 5 || c == 6) begin
                ntests++;
                if (sensor_north !== (c == 5) || (c == 6 && (occupancy !== 3'd3 || sensor_chg !== 1'b1))) begin
                    nfail++; $display("FAIL drop_timing cyc %0d: north %b occ %0d chg %b", c, sensor_north, occupancy, sensor_chg);
                end
            end
            if (c == 10) raw_sensor[0] = 1'b1;
        end
    endtask

    task automatic test_random_sensors();
        for (int c = 1; c <= 320; c++) begin
            @(posedge clk); @(negedge clk);
            ntests++;
            if (dut_vec !== exp_vec) begin nfail++; $display("FAIL rand_sens cyc %0d: got %b want %b", c, dut_vec, exp_vec); end
            if (c < 300) begin
                for (int j = 0; j < 4; j++) if ($urandom_range(5) == 0) raw_sensor[j] = ~raw_sensor[j];
            end else begin
                raw_sensor = 4'hF;
            end
        end
    endtask

    task automatic test_alert_upgrade();
        int first_a2 = 0, a1cnt = 0;
        raw_pol_req = 1'b1;
        for (int c = 1; c <= 45; c++) begin
            @(posedge clk); @(negedge clk);
            ntests++;
            if (dut_vec !== exp_vec) begin nfail++; $display("FAIL upgrade cyc %0d: got %b want %b", c, dut_vec, exp_vec); end
            if (alert2 && first_a2 == 0) first_a2 = c;
            if (alert1) a1cnt++;
            if (c == 11 || c == 12) begin
                ntests++;
                if ({alert1, alert2} !== ((c == 11) ? 2'b01 : 2'b10)) begin
                    nfail++; $display("FAIL upgrade_edge cyc %0d: alert1 %b alert2 %b", c, alert1, alert2);
                end
            end
            if (c == 9) raw_amb_req = 1'b1;
            if (c == 13) raw_amb_req = 1'b0;
            if (c == 20) raw_pol_req = 1'b0;
        end
        ntests++;
        if (first_a2 != 7) begin nfail++; $display("FAIL alert2_latency: got edge %0d want 7", first_a2); end
        ntests++;
        if (a1cnt != 8) begin nfail++; $display("FAIL upgrade_hold: alert1 cycles %0d want 8", a1cnt); end
    endtask

    task automatic test_short_cooldown();
        int a1cnt = 0;
        raw_amb_req = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            @(posedge clk); @(negedge clk);
            ntests++;
            if (dut_vec !== exp_vec || alert1 !== 1'b0) begin
                nfail++; $display("FAIL short_req cyc %0d: got %b want %b", c, dut_vec, exp_vec);
            end
            if (c == 2) raw_amb_req = 1'b0;
        end
        raw_amb_req = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            @(posedge clk); @(negedge clk);
            ntests++;
            if (dut_vec !== exp_vec) begin nfail++; $display("FAIL cooldown cyc %0d: got %b want %b", c, dut_vec, exp_vec); end
            if (alert1) a1cnt++;
            if (c == 6 || c == 25) raw_amb_req = 1'b0;
            if (c == 17) raw_amb_req = 1'b1;
        end
        ntests++;
        if (a1cnt != 8) begin nfail++; $display("FAIL cooldown_hold: alert1 cycles %0d want 8", a1cnt); end
    endtask

    task automatic test_emrg();
        raw_amb_req = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); @(negedge clk);
            ntests++;
            if (dut_vec !== exp_vec) begin nfail++; $display("FAIL emrg cyc %0d: got %b want %b", c, dut_vec, exp_vec); end
            if (c == 11 || (c >= 12 && c <= 25) || c == 30) begin
                ntests++;
                if ((c == 11 && {alert1, emrg} !== 2'b10) || (c >= 12 && c <= 24 && {alert1, emrg} !== 2'b01) ||
                    (c == 25 && emrg !== 1'b0) || (c == 30 && alert1 !== 1'b1)) begin
                    nfail++; $display("FAIL emrg_timing cyc %0d: alert1 %b emrg %b", c, alert1, emrg);
                end
            end
            if (c == 9 || c == 14) raw_manual_emrg = 1'b1;
            if (c == 10 || c == 15) raw_manual_emrg = 1'b0;
            if (c == 30) raw_amb_req = 1'b0;
        end
    endtask

    task automatic test_random_requests();
        for (int c = 1; c <= 680; c++) begin
            @(posedge clk); @(negedge clk);
            ntests++;
            if (dut_vec !== exp_vec) begin nfail++; $display("FAIL rand_req cyc %0d: got %b want %b", c, dut_vec, exp_vec); end
            if (c < 600) begin
                if ($urandom_range(14) == 0) raw_amb_req = ~raw_amb_req;
                if ($urandom_range(9) == 0) raw_pol_req = ~raw_pol_req;
                raw_manual_emrg = ($urandom_range(39) == 0);
                if ($urandom_range(7) == 0) raw_sensor[$urandom_range(3)] ^= 1'b1;
            end else begin
                raw_amb_req = 0; raw_pol_req = 0; raw_manual_emrg = 0; raw_sensor = 4'hF;
            end
        end
    endtask

    task automatic test_rst_mid();
        for (int round = 0; round < 3; round++) begin
            raw_amb_req = 1'b1;
            for (int c = 1; c <= 30; c++) begin
                @(posedge clk); @(negedge clk);
                ntests++;
                if (dut_vec !== exp_vec) begin nfail++; $display("FAIL rst_mid r%0d cyc %0d: got %b want %b", round, c, dut_vec, exp_vec); end
                if (c == 6 || c == 7) begin
                    ntests++;
                    if (alert1 !== (c == 7)) begin nfail++; $display("FAIL rst_requal r%0d cyc %0d: alert1 %b", round, c, alert1); end
                end
                if (c == 7 && round != 0) raw_amb_req = 1'b0;
                if ((round == 0 && c == 10) || (round == 1 && c == 20)) begin
                    #2 rst = 1'b1;
                    #1 ntests++;
                    if (dut_vec !== 11'b0) begin nfail++; $display("FAIL rst_async r%0d: got %b want 0", round, dut_vec); end
                    @(negedge clk);
                    rst = 1'b0;
                    break;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        raw_sensor = 4'hF;
        raw_amb_req = 1'b1;
        raw_pol_req = 1'b1;
        raw_manual_emrg = 1'b1;
        test_reset();
        test_debounce();
        test_random_sensors();
        test_alert_upgrade();
        test_short_cooldown();
        test_emrg();
        test_random_requests();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
